uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_baud_tick.sv | 28 ++
 rtl/uart_tx.sv | 126 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding and frame geometry, reused by the transmitter and receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // 8N1: one start bit, eight data bits, one stop bit
    localparam int unsigned FRAME_BITS = 10;
    localparam int unsigned DATA_BITS  = FRAME_BITS - 2;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the terminal cycle of each period.
module uart_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam logic [15:0] LAST_COUNT = 16'(CLKS_PER_BIT - 1);

    logic [15:0] cnt_r;

    // Period counter, wraps at the terminal count or when cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= 16'd0;
        end else if (clear || (cnt_r == LAST_COUNT)) begin
            cnt_r <= 16'd0;
        end else begin
            cnt_r <= cnt_r + 16'd1;
        end
    end

    assign tick = (cnt_r == LAST_COUNT);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, with registered tx/busy/done and back-to-back frame support.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    uart_state_e state_r, state_s;
    logic [7:0]  shift_r, shift_s;
    logic [2:0]  bit_idx_r, bit_idx_s;
    logic        tx_s, busy_s, done_s;
    logic        tick_s;
    logic        clear_s;

    // The counter rests at zero in IDLE so a start bit always gets a full period
    assign clear_s = (state_r == ST_IDLE);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .clear(clear_s),
        .tick (tick_s)
    );

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            shift_r   <= 8'h00;
            bit_idx_r <= 3'd0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_r   <= state_s;
            shift_r   <= shift_s;
            bit_idx_r <= bit_idx_s;
            tx        <= tx_s;
            busy      <= busy_s;
            done      <= done_s;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_s   = state_r;
        shift_s   = shift_r;
        bit_idx_s = bit_idx_r;
        tx_s      = tx;
        busy_s    = busy;
        done_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (tx_start) begin
                    state_s   = ST_START;
                    shift_s   = tx_data;
                    bit_idx_s = 3'd0;
                    tx_s      = 1'b0;
                    busy_s    = 1'b1;
                end else begin
                    tx_s   = 1'b1;
                    busy_s = 1'b0;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    state_s = ST_DATA;
                    tx_s    = shift_r[0];
                end else begin
                    tx_s = 1'b0;
                end
            end
            ST_DATA: begin
                if (tick_s && (bit_idx_r == LAST_BIT)) begin
                    state_s = ST_STOP;
                    tx_s    = 1'b1;
                end else if (tick_s) begin
                    shift_s   = {1'b0, shift_r[7:1]};
                    bit_idx_s = bit_idx_r + 3'd1;
                    tx_s      = shift_r[1];
                end else begin
                    tx_s = shift_r[0];
                end
            end
            ST_STOP: begin
                // A request at the end of the stop bit chains straight into the next start bit
                if (tick_s && tx_start) begin
                    state_s   = ST_START;
                    shift_s   = tx_data;
                    bit_idx_s = 3'd0;
                    tx_s      = 1'b0;
                    busy_s    = 1'b1;
                    done_s    = 1'b1;
                end else if (tick_s) begin
                    state_s = ST_IDLE;
                    tx_s    = 1'b1;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                end else begin
                    tx_s = 1'b1;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                shift_s   = 8'h00;
                bit_idx_s = 3'd0;
                tx_s      = 1'b1;
                busy_s    = 1'b0;
                done_s    = 1'b0;
            end
        endcase
    end

endmodule
